// File: rtl/eth_sample_packer.sv
// Packs two ADC sample strobes into a shared word FIFO and emits header+payload frames; header valid 2 edges after the enabling write.
// Backpressure: out_ready stalls the frame with outputs held stable; FIFO overflow drops samples and counts them.
module eth_sample_packer #(
    parameter int          FIFO_AW   = 9,
    parameter int          PKT_WORDS = 256,
    parameter logic [15:0] HDR_MAGIC = 16'hE7E7
) (
    input  logic               clk_125,
    input  logic               reset_all,
    input  logic [31:0]        data_1ch,
    input  logic               wr_data_1ch,
    input  logic [31:0]        data_2ch,
    input  logic               wr_data_2ch,
    output logic [31:0]        out_data,
    output logic               out_valid,
    output logic               out_sop,
    output logic               out_eop,
    input  logic               out_ready,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               ovf_flag,
    output logic [15:0]        drop_cnt,
    output logic [15:0]        seq_num
);

    localparam int               DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0] PKT_L   = (FIFO_AW+1)'(PKT_WORDS);
    localparam logic [FIFO_AW:0] LAST_L  = PKT_L - 1'b1;

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

    logic [31:0]        mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr2_addr;
    logic [FIFO_AW:0]   level_q, level_d, free_w, pay_cnt_q, pay_cnt_d;
    logic [15:0]        drop_q, drop_d, seq_q, seq_d;
    logic [16:0]        drop_sum;
    logic               ovf_q, ovf_d;
    logic               acc1, acc2, rd_en;
    logic [1:0]         n_acc, n_drop;
    state_t             state_q, state_d;

    // Space is judged on the pre-edge level: a same-edge read never makes room.
    always_comb begin
        free_w   = DEPTH_L - level_q;
        acc1     = wr_data_1ch && (free_w != '0);
        acc2     = wr_data_2ch && (free_w > (FIFO_AW+1)'(acc1));
        n_acc    = {1'b0, acc1} + {1'b0, acc2};
        n_drop   = {1'b0, wr_data_1ch && !acc1} + {1'b0, wr_data_2ch && !acc2};
        wr2_addr = wr_ptr_q + FIFO_AW'(acc1);
        wr_ptr_d = wr_ptr_q + FIFO_AW'(n_acc);
        drop_sum = {1'b0, drop_q} + 17'(n_drop);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        ovf_d    = ovf_q || (n_drop != 2'd0);
    end

    always_comb begin
        state_d   = state_q;
        pay_cnt_d = pay_cnt_q;
        seq_d     = seq_q;
        rd_en     = 1'b0;
        out_valid = 1'b0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_data  = 32'd0;
        case (state_q)
            IDLE: begin
                if (level_q >= PKT_L) state_d = HDR;
            end
            HDR: begin
                out_valid = 1'b1;
                out_sop   = 1'b1;
                out_data  = {HDR_MAGIC, seq_q};
                if (out_ready) begin
                    state_d   = PAYLOAD;
                    pay_cnt_d = '0;
                end
            end
            PAYLOAD: begin
                // Word at rd_ptr cannot be overwritten while counted in level, so it holds during stalls.
                out_valid = 1'b1;
                out_data  = mem_q[rd_ptr_q];
                out_eop   = (pay_cnt_q == LAST_L);
                if (out_ready) begin
                    rd_en     = 1'b1;
                    pay_cnt_d = pay_cnt_q + 1'b1;
                    if (out_eop) begin
                        seq_d   = seq_q + 16'd1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        rd_ptr_d = rd_ptr_q + FIFO_AW'(rd_en);
        level_d  = level_q + (FIFO_AW+1)'(n_acc) - (FIFO_AW+1)'(rd_en);
    end

    always_ff @(posedge clk_125) begin
        if (acc1) mem_q[wr_ptr_q] <= data_1ch;
        if (acc2) mem_q[wr2_addr] <= data_2ch;
    end

    always_ff @(posedge clk_125) begin
        if (reset_all) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            pay_cnt_q <= '0;
            drop_q    <= 16'd0;
            seq_q     <= 16'd0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            pay_cnt_q <= pay_cnt_d;
            drop_q    <= drop_d;
            seq_q     <= seq_d;
            ovf_q     <= ovf_d;
        end
    end

    assign fifo_level = level_q;
    assign ovf_flag   = ovf_q;
    assign drop_cnt   = drop_q;
    assign seq_num    = seq_q;

endmodule
